// File: rtl/codec_reg_arbiter_if.sv
// Requester command port and WB master-controller command port used by codec_reg_arbiter.
// Requester modports: master = requester side, slave = arbiter side.
`timescale 1ns/1ps

interface codec_req_if;
   logic       valid;
   logic       we;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       ready;
   logic       done;
   logic [7:0] rdata;
   logic       error;

   modport master (output valid, we, addr, wdata,
                   input  ready, done, rdata, error);
   modport slave  (input  valid, we, addr, wdata,
                   output ready, done, rdata, error);
endinterface

// WB modports: master = arbiter side, slave = WB master controller side.
interface codec_wb_if;
   logic       read;
   logic       write;
   logic [3:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       done;

   modport master (output read, write, address, data_in,
                   input  data_out, data_out_valid, done);
   modport slave  (input  read, write, address, data_in,
                   output data_out, data_out_valid, done);
endinterface

// File: rtl/codec_reg_arbiter.sv
// Round-robin arbiter sharing the codec WB master command port between two requesters.
// Optional watchdog on WAIT_DONE enabled by defining CODEC_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

// state     | meaning
// IDLE      | arbitrate; latch granted command
// ISSUE     | pulse ready and wb_read/wb_write for one cycle
// WAIT_DONE | wait for wb_done (or watchdog expiry), then report completion
module codec_reg_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   codec_req_if.slave req0,
   codec_req_if.slave req1,
   codec_wb_if.master wb
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic       gnt_q, gnt_d;
   logic       last_q, last_d;
   logic       we_q, we_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       done_q, done_d;
   logic [7:0] rdata0_q, rdata0_d;
   logic [7:0] rdata1_q, rdata1_d;
   logic       sel;
   logic [7:0] rd_val;
   logic       issue;

`ifdef CODEC_ARB_TIMEOUT_EN
   localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`else
   logic       tc_unused;
   assign tc_unused = ^8'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= 4'h0;
         wdata_q  <= 8'h00;
         done_q   <= 1'b0;
         rdata0_q <= 8'h00;
         rdata1_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

`ifdef CODEC_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'h00;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      done_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      sel      = 1'b0;
      rd_val   = 8'h00;
`ifdef CODEC_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req0.valid || req1.valid) begin
               // Under contention the requester not served last wins.
               if (req0.valid && req1.valid) sel = ~last_q;
               else                          sel = req1.valid;
               gnt_d   = sel;
               last_d  = sel;
               we_d    = sel ? req1.we    : req0.we;
               addr_d  = sel ? req1.addr  : req0.addr;
               wdata_d = sel ? req1.wdata : req0.wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
`ifdef CODEC_ARB_TIMEOUT_EN
            cnt_d = 8'h00;
`endif
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wb.done) begin
               rd_val  = (!we_q && wb.data_out_valid) ? wb.data_out : 8'h00;
               done_d  = 1'b1;
               state_d = IDLE;
               if (gnt_q) rdata1_d = rd_val;
               else       rdata0_d = rd_val;
            end
`ifdef CODEC_ARB_TIMEOUT_EN
            else if (cnt_q == TC_LAST) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
               if (gnt_q) rdata1_d = 8'h00;
               else       rdata0_d = 8'h00;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign issue = (state_q == ISSUE);

   assign req0.ready = issue & ~gnt_q;
   assign req1.ready = issue &  gnt_q;
   assign req0.done  = done_q & ~gnt_q;
   assign req1.done  = done_q &  gnt_q;
   assign req0.rdata = rdata0_q;
   assign req1.rdata = rdata1_q;

`ifdef CODEC_ARB_TIMEOUT_EN
   assign req0.error = done_q & err_q & ~gnt_q;
   assign req1.error = done_q & err_q &  gnt_q;
`else
   assign req0.error = 1'b0;
   assign req1.error = 1'b0;
`endif

   assign wb.read    = issue & ~we_q;
   assign wb.write   = issue &  we_q;
   assign wb.address = addr_q;
   assign wb.data_in = wdata_q;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Directed testbench for codec_reg_arbiter with hand-computed expectations.
`timescale 1ns/1ps

module tb_codec_reg_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic overlap = 1'b0;

   codec_req_if r0 ();
   codec_req_if r1 ();
   codec_wb_if  wb ();

   codec_reg_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .req0  (r0.slave),
      .req1  (r1.slave),
      .wb    (wb.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wb.read && wb.write) overlap <= 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {r0.ready, r0.done, r0.error, r1.ready, r1.done, r1.error,
              wb.read, wb.write, wb.address, wb.data_in, r0.rdata, r1.rdata};
   endfunction

   // Ticks until a ready pulse appears; returns granted index or -1 on timeout.
   task automatic wait_grant(input string tag, output int g);
      g = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (r0.ready) begin g = 0; break; end
         if (r1.ready) begin g = 1; break; end
      end
      if (g < 0) chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
   endtask

   // Controller model: wb_done (with data) after lat cycles from the ISSUE cycle.
   task automatic ctrl_done(input string tag, input int lat, input logic [7:0] d, input logic dv);
      repeat (lat) tick();
      chk({tag, "_no_early_done"}, {62'd0, r0.done, r1.done}, 64'd0);
      wb.done = 1'b1;
      wb.data_out = d;
      wb.data_out_valid = dv;
      tick();
      wb.done = 1'b0;
      wb.data_out_valid = 1'b0;
      wb.data_out = 8'h00;
   endtask

   initial begin
      int g;
      logic seen;
      logic [3:0] exp_addr [4];
      exp_addr[0] = 4'h1; exp_addr[1] = 4'h9; exp_addr[2] = 4'h2; exp_addr[3] = 4'hA;

      r0.valid = 0; r0.we = 0; r0.addr = 0; r0.wdata = 0;
      r1.valid = 0; r1.we = 0; r1.addr = 0; r1.wdata = 0;
      wb.done = 0; wb.data_out = 0; wb.data_out_valid = 0;

      // Reset values
      reset = 1'b1;
      tick(); tick();
      chk("reset_outputs", all_outs(), 64'd0);
      reset = 1'b0;
      tick();

      // Single write from req0
      r0.valid = 1; r0.we = 1; r0.addr = 4'h3; r0.wdata = 8'hA5;
      tick();
      chk("wr_ready0", {63'd0, r0.ready}, 64'd1);
      chk("wr_wb_rw", {62'd0, wb.read, wb.write}, 64'd1);
      chk("wr_addr_data", {52'd0, wb.address, wb.data_in}, {52'd0, 4'h3, 8'hA5});
      chk("wr_ready1_idle", {63'd0, r1.ready}, 64'd0);
      r0.valid = 0; r0.addr = 4'hF; r0.wdata = 8'h00;
      ctrl_done("wr", 4, 8'hEE, 1'b0);
      chk("wr_done0", {62'd0, r0.done, r0.error}, 64'd2);
      chk("wr_addr_held", {52'd0, wb.address, wb.data_in}, {52'd0, 4'h3, 8'hA5});
      chk("wr_rdata0_zero", {56'd0, r0.rdata}, 64'd0);
      tick();
      chk("wr_done_pulse", {63'd0, r0.done}, 64'd0);

      // Single read from req1
      r1.valid = 1; r1.we = 0; r1.addr = 4'h7;
      wait_grant("rd", g);
      chk("rd_grant", g, 1);
      chk("rd_wb_rw", {52'd0, wb.read, wb.write, 6'd0, wb.address}, {52'd0, 2'b10, 6'd0, 4'h7});
      r1.valid = 0;
      ctrl_done("rd", 2, 8'h5C, 1'b1);
      chk("rd_done1", {52'd0, r1.done, r1.error, 2'd0, r1.rdata}, {52'd0, 2'b10, 2'd0, 8'h5C});
      chk("rd_req0_quiet", {52'd0, r0.ready, r0.done, r0.error, 1'b0, r0.rdata}, 64'd0);

      // Stray done in IDLE
      tick();
      wb.done = 1'b1; wb.data_out = 8'h99; wb.data_out_valid = 1'b1;
      tick();
      wb.done = 1'b0; wb.data_out_valid = 1'b0;
      tick();
      chk("stray_no_done", {62'd0, r0.done, r1.done}, 64'd0);
      chk("stray_rdata_held", {48'd0, r0.rdata, r1.rdata}, {48'd0, 8'h00, 8'h5C});
      r0.valid = 1; r0.we = 0; r0.addr = 4'h5;
      wait_grant("stray_next", g);
      chk("stray_next_grant", g, 0);
      r0.valid = 0;
      ctrl_done("stray_next", 3, 8'h3C, 1'b1);
      chk("stray_next_done0", {62'd0, r0.done, r0.error}, 64'd2);
      chk("stray_next_rdata", {48'd0, r0.rdata, r1.rdata}, {48'd0, 8'h3C, 8'h5C});

      // Read without data_out_valid returns 0x00
      r1.valid = 1; r1.we = 0; r1.addr = 4'h2;
      wait_grant("nodv", g);
      r1.valid = 0;
      ctrl_done("nodv", 1, 8'hEE, 1'b0);
      chk("nodv_rdata1", {55'd0, r1.done, r1.rdata}, {55'd0, 1'b1, 8'h00});

      // Contention from reset: r0 writes 1/2, r1 reads 9/A
      reset = 1'b1;
      r0.valid = 1; r0.we = 1; r0.addr = 4'h1; r0.wdata = 8'h11;
      r1.valid = 1; r1.we = 0; r1.addr = 4'h9;
      tick(); tick();
      reset = 1'b0;
      overlap = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_grant("cont", g);
         chk($sformatf("cont_grant_%0d", k), g, k % 2);
         chk($sformatf("cont_addr_%0d", k), {60'd0, wb.address}, {60'd0, exp_addr[k]});
         if (k == 0) begin r0.addr = 4'h2; r0.wdata = 8'h22; end
         if (k == 1) r1.addr = 4'hA;
         if (k == 2) r0.valid = 0;
         if (k == 3) r1.valid = 0;
         ctrl_done("cont", 1, 8'h80 + 8'(k), 1'b1);
         chk($sformatf("cont_done_%0d", k), {62'd0, r1.done, r0.done}, (k % 2) ? 64'd2 : 64'd1);
      end
      chk("cont_rdata", {48'd0, r0.rdata, r1.rdata}, {48'd0, 8'h00, 8'h83});
      chk("cont_no_overlap", {63'd0, overlap}, 64'd0);

      // Reset during WAIT_DONE
      tick();
      r0.valid = 1; r0.we = 1; r0.addr = 4'h6; r0.wdata = 8'h99;
      wait_grant("rst", g);
      r0.valid = 0;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rst_outputs", all_outs(), 64'd0);
      reset = 1'b0;
      tick(); tick();
      wb.done = 1'b1; wb.data_out = 8'h44; wb.data_out_valid = 1'b1;
      tick();
      wb.done = 1'b0; wb.data_out_valid = 1'b0;
      chk("rst_late_done_a", {62'd0, r0.done, r1.done}, 64'd0);
      tick();
      chk("rst_late_done_b", {62'd0, r0.done, r1.done}, 64'd0);
      r1.valid = 1; r1.we = 0; r1.addr = 4'h4;
      wait_grant("rst_next", g);
      chk("rst_next_grant", g, 1);
      r1.valid = 0;
      ctrl_done("rst_next", 3, 8'h21, 1'b1);
      chk("rst_next_done1", {55'd0, r1.done, r1.rdata}, {55'd0, 1'b1, 8'h21});

`ifdef CODEC_ARB_TIMEOUT_EN
      // Give rdata0 a nonzero value so the timeout clear is visible
      r0.valid = 1; r0.we = 0; r0.addr = 4'h1;
      wait_grant("pre_to", g);
      r0.valid = 0;
      ctrl_done("pre_to", 1, 8'h77, 1'b1);
      chk("pre_to_rdata0", {56'd0, r0.rdata}, {56'd0, 8'h77});

      // Timeout after 16 WAIT_DONE cycles
      r0.valid = 1; r0.we = 0; r0.addr = 4'h8;
      wait_grant("to", g);
      r0.valid = 0;
      repeat (16) tick();
      chk("to_not_yet", {63'd0, r0.done}, 64'd0);
      tick();
      chk("to_done_err", {54'd0, r0.done, r0.error, r0.rdata}, {54'd0, 2'b11, 8'h00});
      chk("to_req1_quiet", {62'd0, r1.done, r1.error}, 64'd0);
      tick();
      chk("to_pulse", {62'd0, r0.done, r0.error}, 64'd0);

      // wb_done in the expiry cycle is a normal completion
      r0.valid = 1; r0.we = 0; r0.addr = 4'h8;
      wait_grant("to_edge", g);
      r0.valid = 0;
      repeat (16) tick();
      wb.done = 1'b1; wb.data_out = 8'h66; wb.data_out_valid = 1'b1;
      tick();
      wb.done = 1'b0; wb.data_out_valid = 1'b0;
      chk("to_edge_normal", {54'd0, r0.done, r0.error, r0.rdata}, {54'd0, 2'b10, 8'h66});
`else
      // Without the watchdog the block waits indefinitely
      r0.valid = 1; r0.we = 0; r0.addr = 4'h8;
      wait_grant("hang", g);
      r0.valid = 0;
      seen = 1'b0;
      repeat (1000) begin
         tick();
         if (r0.done || r1.done || r0.error) seen = 1'b1;
      end
      chk("hang_no_done", {63'd0, seen}, 64'd0);
      wb.done = 1'b1; wb.data_out = 8'h66; wb.data_out_valid = 1'b1;
      tick();
      wb.done = 1'b0; wb.data_out_valid = 1'b0;
      chk("hang_then_done", {54'd0, r0.done, r0.error, r0.rdata}, {54'd0, 2'b10, 8'h66});
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
